seg_scan_ctrl: RTL and testbench
================================

// Module: seg_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for the shared 7-segment decoder (4-bit BCD in, 8-bit seg out,
//  codes >=10 decode to blank). Holds a NUM_DIGITS-wide BCD frame and feeds one digit at a time.
//  Drives the decoder input plus active-low digit selects, with dead time between digits to stop ghosting.
//  New frames arrive through a ready/load handshake and are committed only at frame boundaries (tear-free).
// PARAMETERS
//  NUM_DIGITS  8      digits scanned; legal 2..8
//  DIV         50000  clk cycles each digit is lit (SHOW phase); >=1
//  BLANK_CYC   16     clk cycles all digits off before each digit (BLANK phase); >=1
//  CNT_W       16     phase counter width; must hold max(DIV,BLANK_CYC)-1
// PORTS
//  clk          in   1             system clock, rising edge
//  rst          in   1             synchronous, active-high reset
//  load         in   1             request to capture data_in; accepted when load && ready
//  data_in      in   4*NUM_DIGITS  BCD frame; nibble i = digit i, digit 0 = least significant
//  ready        out  1             1 = shadow buffer free, load accepted
//  digit_code   out  4             BCD to decoder; 4'hF = blank
//  dig_sel      out  NUM_DIGITS    digit enables, active-low, at most one bit low
//  frame_start  out  1             1-cycle pulse on first SHOW cycle of digit 0
// BEHAVIOUR
//  Reset (rst high at clk edge): state=BLANK, phase cnt=0, idx=0, dig_sel=all 1, digit_code=4'hF,
//   active frame=all 4'hF, shadow=all 4'hF, pending=0, ready=1, frame_start=0. rst wins over all inputs;
//   reset mid-frame or mid-handshake discards the pending shadow.
//  All outputs registered; they change on the same edge as the state register.
//  FSM: BLANK -> SHOW after BLANK_CYC cycles; SHOW -> BLANK after DIV cycles. cnt clears on each transition.
//   BLANK: dig_sel=all 1, digit_code=4'hF.
//   SHOW: dig_sel[idx]=0, others 1; digit_code=active[idx] (after blanking rule below).
//  idx increments on SHOW->BLANK; wraps NUM_DIGITS-1 -> 0. Frame period = NUM_DIGITS*(BLANK_CYC+DIV).
//  Commit: on the SHOW->BLANK edge with idx wrapping to 0, if pending: active<=shadow, pending<=0,
//   ready<=1 (visible next cycle). Otherwise active frame unchanged.
//  Load: on edge with load && ready: shadow<=data_in, pending<=1, ready<=0. load while ready=0 is
//   ignored (no capture, no error); requester holds load until it sees ready.
//  Simultaneous commit edge and load: ready is 0 there, so load is ignored; accepted earliest next cycle.
//  Codes 10..15 in data_in pass through unchanged (decoder blanks them); no range checking.
//  frame_start pulses exactly once per frame, on the BLANK->SHOW edge with idx=0.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined: in SHOW, digit idx outputs 4'hF if active[idx] and every higher
//   nibble are 4'h0; digit 0 is never blanked (frame 0000 shows "0"). dig_sel behaviour unchanged.
//  Undefined: digit_code = active[idx] always; leading zeros displayed.
// TESTING (NUM_DIGITS=4, DIV=4, BLANK_CYC=2 -> 24-cycle frame)
//  1 Reset: rst 1 for 3 cycles -> dig_sel=4'b1111, digit_code=F, ready=1; after release first SHOW at
//    cycle 2 with dig_sel=4'b1110, code F; frame_start pulses every 24 cycles.
//  2 Scan order: load 16'h4321 -> after next commit, SHOW codes 1,2,3,4 on dig_sel 1110,1101,1011,0111,
//    each lit exactly 4 cycles, 2 all-off cycles between; never two selects low.
//  3 Handshake: load 16'h9876 mid-frame -> ready=0 next cycle; displayed frame unchanged until wrap;
//    second load 16'h1111 while ready=0 ignored; ready=1 the cycle after commit, display 9876.
//  4 Load on commit edge: assert load 16'h5555 exactly on the commit edge -> ignored; held one more
//    cycle -> accepted, committed at following frame.
//  5 Reset mid-handshake: load 16'h2222, rst during same frame -> all blank, ready=1, 2222 never shown.
//  6 LEADING_ZERO_BLANK_EN: frame 16'h0050 -> digit3,2 code F, digit1 5, digit0 0; 16'h0000 -> only
//    digit0 shows 0. Without macro: 16'h0050 shows 0,0,5,0.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Scan controller feeding one BCD digit at a time to a shared 7-segment decoder with dead time.
// Optional build macro LEADING_ZERO_BLANK_EN: suppress leading zeros (digit 0 always shown).
module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int DIV        = 50000,
  parameter int BLANK_CYC  = 16,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  output logic                    ready,
  output logic [3:0]              digit_code,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_start
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [0:0] {ST_BLANK = 1'b0, ST_SHOW = 1'b1} state_t;

  state_t                  state_r, state_nx_s;
  logic [CNT_W-1:0]        cnt_r, cnt_nx_s;
  logic [IDX_W-1:0]        idx_r, idx_nx_s;
  logic [4*NUM_DIGITS-1:0] active_r, shadow_r;
  logic                    pending_r, ready_r;
  logic [3:0]              digit_code_r, code_nx_s;
  logic [NUM_DIGITS-1:0]   dig_sel_r, sel_nx_s;
  logic                    frame_start_r, fs_nx_s;
  logic                    wrap_s;

  // Code shown for digit idx of a frame; leading zeros may be suppressed above digit 0.
  function automatic logic [3:0] pick_code(input logic [4*NUM_DIGITS-1:0] frame,
                                           input logic [IDX_W-1:0]        idx);
    logic [3:0] code;
    code = frame[{idx, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    if ((idx != {IDX_W{1'b0}}) && ((frame >> {idx, 2'b00}) == {(4*NUM_DIGITS){1'b0}})) begin
      code = 4'hF;
    end else begin
      code = code;
    end
`endif
    return code;
  endfunction

  // Phase sequencing plus the output values that will be registered alongside the next state.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r + 1'b1;
    idx_nx_s   = idx_r;
    wrap_s     = 1'b0;
    sel_nx_s   = {NUM_DIGITS{1'b1}};
    code_nx_s  = 4'hF;
    fs_nx_s    = 1'b0;
    case (state_r)
      ST_BLANK: begin
        if (cnt_r == BLANK_LAST) begin
          state_nx_s = ST_SHOW;
          cnt_nx_s   = {CNT_W{1'b0}};
        end else begin
          state_nx_s = ST_BLANK;
        end
      end
      ST_SHOW: begin
        if (cnt_r == SHOW_LAST) begin
          state_nx_s = ST_BLANK;
          cnt_nx_s   = {CNT_W{1'b0}};
          if (idx_r == LAST_IDX) begin
            idx_nx_s = {IDX_W{1'b0}};
            wrap_s   = 1'b1;
          end else begin
            idx_nx_s = idx_r + 1'b1;
          end
        end else begin
          state_nx_s = ST_SHOW;
        end
      end
      default: begin
        state_nx_s = ST_BLANK;
        cnt_nx_s   = {CNT_W{1'b0}};
        idx_nx_s   = {IDX_W{1'b0}};
      end
    endcase
    // The active frame only changes while entering BLANK, so it is stable for every SHOW cycle.
    if (state_nx_s == ST_SHOW) begin
      sel_nx_s[idx_nx_s] = 1'b0;
      code_nx_s          = pick_code(active_r, idx_nx_s);
      fs_nx_s            = (state_r == ST_BLANK) && (idx_nx_s == {IDX_W{1'b0}});
    end else begin
      sel_nx_s  = {NUM_DIGITS{1'b1}};
      code_nx_s = 4'hF;
      fs_nx_s   = 1'b0;
    end
  end

  // State, frame buffers, handshake and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_BLANK;
      cnt_r         <= {CNT_W{1'b0}};
      idx_r         <= {IDX_W{1'b0}};
      active_r      <= {NUM_DIGITS{4'hF}};
      shadow_r      <= {NUM_DIGITS{4'hF}};
      pending_r     <= 1'b0;
      ready_r       <= 1'b1;
      digit_code_r  <= 4'hF;
      dig_sel_r     <= {NUM_DIGITS{1'b1}};
      frame_start_r <= 1'b0;
    end else begin
      state_r       <= state_nx_s;
      cnt_r         <= cnt_nx_s;
      idx_r         <= idx_nx_s;
      digit_code_r  <= code_nx_s;
      dig_sel_r     <= sel_nx_s;
      frame_start_r <= fs_nx_s;
      // A pending commit implies ready is low, so commit and capture never collide.
      if (wrap_s && pending_r) begin
        active_r  <= shadow_r;
        pending_r <= 1'b0;
        ready_r   <= 1'b1;
      end else if (load && ready_r) begin
        shadow_r  <= data_in;
        pending_r <= 1'b1;
        ready_r   <= 1'b0;
      end else begin
        pending_r <= pending_r;
        ready_r   <= ready_r;
      end
    end
  end

  assign ready       = ready_r;
  assign digit_code  = digit_code_r;
  assign dig_sel     = dig_sel_r;
  assign frame_start = frame_start_r;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: frame-level reference model plus directed scenarios.
module tb_seg_scan_ctrl;
  localparam int ND    = 4;
  localparam int DIVP  = 4;
  localparam int BLK   = 2;
  localparam int SLOT  = BLK + DIVP;
  localparam int FRAME = ND * SLOT;

  logic        clk = 1'b0;
  logic        rst, load;
  logic [15:0] data_in;
  logic        ready, frame_start;
  logic [3:0]  digit_code;
  logic [3:0]  dig_sel;

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;

  // model state
  int          m_n;
  logic [15:0] m_active, m_shadow;
  logic        m_pending, m_ready;

  seg_scan_ctrl #(.NUM_DIGITS(ND), .DIV(DIVP), .BLANK_CYC(BLK), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .ready(ready),
    .digit_code(digit_code), .dig_sel(dig_sel), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: position in frame counts edges since reset; commits occur when position returns to 0.
  always @(posedge clk) begin
    if (rst) begin
      m_n <= 0; m_active <= 16'hFFFF; m_shadow <= 16'hFFFF; m_pending <= 1'b0; m_ready <= 1'b1;
    end else begin
      m_n <= m_n + 1;
      if (((m_n + 1) % FRAME == 0) && m_pending) begin
        m_active <= m_shadow; m_pending <= 1'b0; m_ready <= 1'b1;
      end else if (load && m_ready) begin
        m_shadow <= data_in; m_pending <= 1'b1; m_ready <= 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      int pos, slot, q;
      logic [3:0] e_sel, e_code;
      logic e_fs;
      pos = m_n % FRAME; slot = pos / SLOT; q = pos % SLOT;
      e_sel = 4'b1111; e_code = 4'hF; e_fs = 1'b0;
      if (q >= BLK) begin
        e_sel[slot] = 1'b0;
        e_code = 4'((m_active >> (4 * slot)) & 16'h000F);
`ifdef LEADING_ZERO_BLANK_EN
        if (slot > 0 && (m_active >> (4 * slot)) == 16'h0000) e_code = 4'hF;
`endif
        e_fs = (slot == 0) && (q == BLK);
      end
      check("model_dig_sel", 16'(dig_sel), 16'(e_sel));
      check("model_digit_code", 16'(digit_code), 16'(e_code));
      check("model_frame_start", 16'(frame_start), 16'(e_fs));
      check("model_ready", 16'(ready), 16'(m_ready));
    end
  end

  task automatic wait_fs();
    bit seen = 1'b0;
    for (int i = 0; i < 3 * FRAME && !seen; i++) begin
      @(negedge clk);
      if (frame_start) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL frame_start_timeout: got none expected pulse within %0d cycles", 3 * FRAME);
    end
  endtask

  task automatic do_load(input logic [15:0] d);
    int n = 0;
    while (!ready && n < 4 * FRAME) begin
      @(negedge clk); n++;
    end
    checks++;
    if (!ready) begin
      errors++;
      $display("FAIL ready_timeout: got ready=0 expected ready=1");
    end
    load = 1'b1; data_in = d;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; data_in = 16'h0000;
    step(3);
    chk_en = 1'b1;
    // 1: reset state and first SHOW
    check("rst_dig_sel", 16'(dig_sel), 16'h000F);
    check("rst_code", 16'(digit_code), 16'h000F);
    check("rst_ready", 16'(ready), 16'h0001);
    rst = 1'b0;
    step(2);
    check("first_show_sel", 16'(dig_sel), 16'h000E);
    check("first_show_code", 16'(digit_code), 16'h000F);
    check("first_frame_start", 16'(frame_start), 16'h0001);

    // 2: scan order
    do_load(16'h4321);
    wait_fs();
    check("scan_d0_code", 16'(digit_code), 16'h0001);
    step(SLOT);
    check("scan_d1_code", 16'(digit_code), 16'h0002);
    check("scan_d1_sel", 16'(dig_sel), 16'h000D);
    step(2 * SLOT);
    check("scan_d3_code", 16'(digit_code), 16'h0004);
    check("scan_d3_sel", 16'(dig_sel), 16'h0007);

    // 3: handshake, second load while busy is ignored
    do_load(16'h9876);
    check("busy_ready", 16'(ready), 16'h0000);
    load = 1'b1; data_in = 16'h1111;
    step(3);
    load = 1'b0;
    wait_fs();
    check("hs_code", 16'(digit_code), 16'h0006);
    check("hs_ready", 16'(ready), 16'h0001);

    // 4: load asserted on the commit edge is ignored, accepted one cycle later
    do_load(16'h0050);
    for (int i = 0; i < 2 * FRAME && (m_n % FRAME) != FRAME - 1; i++) @(negedge clk);
    load = 1'b1; data_in = 16'h5555;
    step(1);
    check("commit_edge_ready", 16'(ready), 16'h0001);
    step(1);
    check("held_load_ready", 16'(ready), 16'h0000);
    load = 1'b0;
    wait_fs();
    check("lz_d0_code", 16'(digit_code), 16'h0000);
    step(SLOT);
    check("lz_d1_code", 16'(digit_code), 16'h0005);
    step(SLOT);
    check("lz_d2_sel", 16'(dig_sel), 16'h000B);
`ifdef LEADING_ZERO_BLANK_EN
    check("lz_d2_code", 16'(digit_code), 16'h000F);
`else
    check("lz_d2_code", 16'(digit_code), 16'h0000);
`endif
    wait_fs();
    check("held_load_code", 16'(digit_code), 16'h0005);
    do_load(16'h0000);
    wait_fs();
    check("zero_d0_code", 16'(digit_code), 16'h0000);
    step(FRAME - 2);

    // 5: reset mid-handshake discards the pending frame
    do_load(16'h2222);
    step(5);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("rst2_sel", 16'(dig_sel), 16'h000F);
    check("rst2_code", 16'(digit_code), 16'h000F);
    check("rst2_ready", 16'(ready), 16'h0001);
    wait_fs();
    check("rst2_f1_code", 16'(digit_code), 16'h000F);
    wait_fs();
    check("rst2_f2_code", 16'(digit_code), 16'h000F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
